// File: rtl/sik_defs.sv
// Shared definitions for the stack-processor memory arbiter.
//   WORD_W / ADDR_W     : data and address widths
//   tid_t               : hardware thread id (thread 0 / thread 1)
//   arb_state_t         : arbiter states IDLE / BUSY
//   req_t               : one thread's request payload
//   MEM_LAT_DEF / MAX_LOCK_DEF : parameter defaults
package sik_defs;
  localparam int WORD_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int MEM_LAT_DEF  = 1;
  localparam int MAX_LOCK_DEF = 8;

  typedef logic tid_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/sik_rr_pick.sv
// Combinational 2-way round-robin chooser.
//   elig        : per-thread eligibility (req & ~halt)
//   last        : thread granted most recently
//   lock_valid  : a lock is held; only lock_owner may be chosen
//   lock_owner  : thread holding the lock
//   grant_valid : some thread is chosen
//   grant_id    : chosen thread
module sik_rr_pick
  import sik_defs::*;
(
  input  logic [1:0] elig,
  input  tid_t       last,
  input  logic       lock_valid,
  input  tid_t       lock_owner,
  output logic       grant_valid,
  output tid_t       grant_id
);
  logic [1:0] w_elig;

  always_comb begin
    w_elig = elig;
    if (lock_valid)
      w_elig = elig & (lock_owner ? 2'b10 : 2'b01);
    grant_valid = |w_elig;
    // on a tie the thread that did not go last wins
    if (&w_elig) grant_id = ~last;
    else         grant_id = w_elig[1];
  end
endmodule

// File: rtl/sik_mem_arbiter.sv
// Shares the single-port 64K x 16 main memory between the two hardware
// threads. Round-robin grant, one outstanding read, optional lock for
// atomic read-modify-write with a forced-release timeout, halt masking.
//   clk, reset              : clock, synchronous active-high reset
//   reqX/weX/lockX/addrX/wdataX : thread X request (held until gntX)
//   haltX                   : masks thread X requests
//   gntX                    : combinational grant, same cycle as issue
//   rvalidX/rdataX          : read response strobe / held read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   lock_err                : one-cycle pulse on lock timeout release
module sik_mem_arbiter
  import sik_defs::*;
#(
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  input  logic              halt0,
  input  logic              halt1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              lock_err
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int TMR_W = $clog2(MAX_LOCK + 1);

  arb_state_t        r_state;
  logic [LAT_W-1:0]  r_lat;
  tid_t              r_last;
  tid_t              r_rd_id;
  logic              r_locked;
  tid_t              r_owner;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rvalid0, r_rvalid1;
  logic [WORD_W-1:0] r_rdata0, r_rdata1;

  logic [1:0] w_elig;
  logic       w_pick_vld;
  tid_t       w_pick_id;
  logic       w_issue;
  req_t       w_sel;
  logic       w_tmo;
  logic       w_own_halt;
  logic       w_own_unlock;

  assign w_elig = {req1 & ~halt1, req0 & ~halt0};

  sik_rr_pick u_pick (
    .elig        (w_elig),
    .last        (r_last),
    .lock_valid  (r_locked),
    .lock_owner  (r_owner),
    .grant_valid (w_pick_vld),
    .grant_id    (w_pick_id)
  );

  always_comb begin
    w_sel = w_pick_id ? req_t'{we: we1, lock: lock1, addr: addr1, wdata: wdata1}
                      : req_t'{we: we0, lock: lock0, addr: addr0, wdata: wdata0};
  end

  // outputs are forced quiet while reset is asserted
  assign w_issue   = w_pick_vld & (r_state == IDLE) & ~reset;
  assign gnt0      = w_issue & ~w_pick_id;
  assign gnt1      = w_issue &  w_pick_id;
  assign mem_en    = w_issue;
  assign mem_we    = w_issue & w_sel.we;
  assign mem_addr  = w_issue ? w_sel.addr  : '0;
  assign mem_wdata = w_issue ? w_sel.wdata : '0;

  // timer is cleared at the lock grant, so it reads MAX_LOCK-1 in the
  // MAX_LOCK-th cycle after that grant
  assign w_tmo        = r_locked & (r_timer == TMR_W'(MAX_LOCK - 1));
  assign w_own_halt   = r_locked & (r_owner ? halt1 : halt0);
  assign w_own_unlock = r_locked & w_issue & (w_pick_id == r_owner) & ~w_sel.lock;
  assign lock_err     = w_tmo & ~reset;

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_last    <= 1'b1;
      r_rd_id   <= 1'b0;
      r_locked  <= 1'b0;
      r_owner   <= 1'b0;
      r_timer   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_last <= w_pick_id;
            if (!w_sel.we) begin
              r_state <= BUSY;
              r_lat   <= LAT_W'(MEM_LAT - 1);
              r_rd_id <= w_pick_id;
            end
          end
        end
        BUSY: begin
          if (r_lat == '0) begin
            // response cycle overlaps the next possible grant
            r_state <= IDLE;
            if (r_rd_id) begin
              r_rvalid1 <= 1'b1;
              r_rdata1  <= mem_rdata;
            end else begin
              r_rvalid0 <= 1'b1;
              r_rdata0  <= mem_rdata;
            end
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // release has priority over any lock request in the same cycle
      if (w_tmo || w_own_halt || w_own_unlock) begin
        r_locked <= 1'b0;
        r_timer  <= '0;
      end else if (w_issue && w_sel.lock) begin
        r_locked <= 1'b1;
        r_owner  <= w_pick_id;
        r_timer  <= '0;
      end else if (r_locked) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end
endmodule
